lfsr_sched: RTL and testbench

LFSR_SCHED -- requirements
Module: lfsr_sched

---
 rtl/lfsr_sched.sv | 125 ++++++++++++
 tb/tb_lfsr_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_sched.sv
// lfsr_sched: 5-bit maximal-length LFSR shared by two requesters, plus a
// free-running tick divider that steps the LFSR when run is enabled.
// Ports: clk_50/reset (async, active-high); seed_load/seed_in reseed the LFSR;
//   run gates tick-driven stepping; req[1:0] demand words, answered by a
//   one-hot gnt pulse with rnd_data/rnd_valid; lfsr, tick and busy expose state.
module lfsr_sched #(
  parameter logic [4:0] SEED = 5'b00001,
  parameter int         DIV  = 50_000_000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       seed_load,
  input  logic [4:0] seed_in,
  input  logic       run,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic [4:0] rnd_data,
  output logic       rnd_valid,
  output logic [4:0] lfsr,
  output logic       tick,
  output logic       busy
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, GRANT, STEP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          tick_pend;
  logic          last_gnt;
  logic          gnt_idx;
  logic [4:0]    lfsr_step;
  logic          enter_step;

  // Tick divider runs regardless of what the FSM is doing.
  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign lfsr_step = {lfsr[0] ^ lfsr[2], lfsr[4:1]};

  // Round-robin: on contention pick the requester not served last time.
  assign gnt_idx = (req == 2'b11) ? ~last_gnt : req[1];

  // State register
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: every non-IDLE state is a single cycle.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (seed_load)      state_nxt = LOAD;
        else if (|req)      state_nxt = GRANT;
        else if (tick_pend) state_nxt = STEP;
        else                state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state != IDLE);
  end

  assign enter_step = (state == IDLE) && (state_nxt == STEP);

  // Actions are performed on the edge that enters LOAD/GRANT/STEP, so the
  // registered results are visible for exactly the one cycle spent there.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      lfsr      <= SEED;
      gnt       <= 2'b00;
      rnd_valid <= 1'b0;
      rnd_data  <= 5'b00000;
      last_gnt  <= 1'b1;
    end else begin
      gnt       <= 2'b00;
      rnd_valid <= 1'b0;
      if (state == IDLE) begin
        case (state_nxt)
          LOAD: lfsr <= (seed_in == 5'b00000) ? SEED : seed_in;
          GRANT: begin
            gnt       <= gnt_idx ? 2'b10 : 2'b01;
            rnd_valid <= 1'b1;
            rnd_data  <= lfsr;
            lfsr      <= lfsr_step;
            last_gnt  <= gnt_idx;
          end
          STEP:    lfsr <= lfsr_step;
          default: ;
        endcase
      end
    end
  end

  // Pending free-run step; the clear on STEP entry wins over a coincident tick
  // so ticks never accumulate.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      tick_pend <= 1'b0;
    end else if (enter_step) begin
      tick_pend <= 1'b0;
    end else if (tick && run) begin
      tick_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lfsr_sched.sv
// Bench for lfsr_sched: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a reference model.
module tb_lfsr_sched;

  localparam int         DIV  = 4;
  localparam logic [4:0] SEED = 5'b00001;

  logic       clk_50 = 1'b0;
  logic       reset;
  logic       seed_load;
  logic [4:0] seed_in;
  logic       run;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [4:0] rnd_data;
  logic       rnd_valid;
  logic [4:0] lfsr;
  logic       tick;
  logic       busy;

  lfsr_sched #(.SEED(SEED), .DIV(DIV)) dut (
    .clk_50(clk_50), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .run(run), .req(req), .gnt(gnt), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
    .lfsr(lfsr), .tick(tick), .busy(busy)
  );

  always #5 clk_50 = ~clk_50;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the block is either free (can accept a new action) or
  // occupied for exactly one cycle by the action it just started.
  typedef struct packed {
    logic [4:0] lfsr;
    logic [4:0] data;
    logic [1:0] gnt;
    logic       valid;
    logic       occupied;
    logic       pend;
    logic       last;
    logic [7:0] cnt;
  } mstate_t;

  mstate_t m;

  function automatic logic [4:0] next_word(input logic [4:0] s);
    return {s[0] ^ s[2], s[4:1]};
  endfunction

  function automatic mstate_t m_reset();
    mstate_t r;
    r.lfsr = SEED; r.data = 5'd0; r.gnt = 2'd0; r.valid = 1'b0;
    r.occupied = 1'b0; r.pend = 1'b0; r.last = 1'b1; r.cnt = 8'd0;
    return r;
  endfunction

  function automatic mstate_t m_next(input mstate_t s, input logic sl,
                                     input logic [4:0] si, input logic rn,
                                     input logic [1:0] rq);
    mstate_t n;
    int      who;
    logic    ticking;
    logic    stepped;
    n = s;
    n.gnt = 2'd0;
    n.valid = 1'b0;
    n.occupied = 1'b0;
    stepped = 1'b0;
    ticking = (int'(s.cnt) == DIV - 1);
    if (!s.occupied) begin
      if (sl) begin
        n.lfsr = (si == 5'd0) ? SEED : si;
        n.occupied = 1'b1;
      end else if (rq != 2'd0) begin
        if (rq == 2'b11) who = s.last ? 0 : 1;
        else             who = rq[1] ? 1 : 0;
        n.gnt = (who == 1) ? 2'b10 : 2'b01;
        n.valid = 1'b1;
        n.data = s.lfsr;
        n.lfsr = next_word(s.lfsr);
        n.last = (who == 1);
        n.occupied = 1'b1;
      end else if (s.pend) begin
        n.lfsr = next_word(s.lfsr);
        n.pend = 1'b0;
        n.occupied = 1'b1;
        stepped = 1'b1;
      end
    end
    if (!stepped && ticking && rn) n.pend = 1'b1;
    n.cnt = ticking ? 8'd0 : s.cnt + 8'd1;
    return n;
  endfunction

  always @(posedge clk_50 or posedge reset) begin
    if (reset) m <= m_reset();
    else       m <= m_next(m, seed_load, seed_in, run, req);
  end

  // Single compare process, away from the active edge.
  always @(negedge clk_50) begin
    if (chk_en) begin
      chk("gnt",       gnt,       m.gnt);
      chk("rnd_valid", rnd_valid, m.valid);
      chk("rnd_data",  rnd_data,  m.data);
      chk("lfsr",      lfsr,      m.lfsr);
      chk("tick",      tick,      (int'(m.cnt) == DIV - 1));
      chk("busy",      busy,      m.occupied);
    end
  end

  task automatic wait_change(input logic [4:0] p, output logic [4:0] v, output bit ok);
    ok = 1'b0;
    v  = p;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_50);
      if (lfsr !== p) begin
        ok = 1'b1;
        v  = lfsr;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL lfsr_change_timeout: actual=%0h required=change", p);
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_50);
      if (rnd_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual=no_grant required=grant", name);
  endtask

  logic [4:0] fr_exp [5];
  logic [1:0] rr_gnt [4];
  logic [4:0] rr_dat [4];

  initial begin
    logic [4:0] prev;
    logic [4:0] v;
    bit         ok;
    int         first_ret;
    int         t_last;
    int         ticks_seen;
    bit         busy_seen;

    fr_exp = '{5'b00001, 5'b10000, 5'b01000, 5'b00100, 5'b10010};
    rr_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    rr_dat = '{5'b00001, 5'b10000, 5'b01000, 5'b00100};

    reset = 1'b1; seed_load = 1'b0; seed_in = 5'd0; run = 1'b0; req = 2'd0;
    repeat (2) @(negedge clk_50);
    chk("rst_lfsr", lfsr, 5'b00001);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_valid", rnd_valid, 1'b0);
    chk("rst_data", rnd_data, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tick", tick, 1'b0);
    chk_en = 1'b1;
    reset = 1'b0;

    // Free-run sequence and full period.
    run = 1'b1;
    prev = lfsr;
    chk("fr_start", prev, fr_exp[0]);
    first_ret = 0;
    for (int i = 1; i <= 31; i++) begin
      wait_change(prev, v, ok);
      if (!ok) break;
      if (i < 5) chk($sformatf("fr_step%0d", i), v, fr_exp[i]);
      if (v == 5'b00001 && first_ret == 0) first_ret = i;
      prev = v;
    end
    chk("fr_period", first_ret, 31);
    run = 1'b0;
    repeat (10) @(negedge clk_50);

    // Seed guard.
    seed_in = 5'b10110; seed_load = 1'b1;
    @(negedge clk_50);
    seed_load = 1'b0;
    chk("seed_10110", lfsr, 5'b10110);
    @(negedge clk_50);
    seed_in = 5'b00000; seed_load = 1'b1;
    @(negedge clk_50);
    seed_load = 1'b0;
    chk("seed_zero", lfsr, 5'b00001);
    @(negedge clk_50);

    // Run gate: ticks with run low must not step the LFSR.
    ticks_seen = 0;
    busy_seen  = 1'b0;
    repeat (14) begin
      @(negedge clk_50);
      if (tick) ticks_seen++;
      if (busy) busy_seen = 1'b1;
    end
    chk("gate_ticks_ge3", ticks_seen >= 3, 1'b1);
    chk("gate_lfsr", lfsr, 5'b00001);
    chk("gate_busy", busy_seen, 1'b0);
    chk("gate_pend", dut.tick_pend, 1'b0);

    // Round-robin from reset with both requesters held.
    reset = 1'b1; req = 2'b11;
    @(negedge clk_50);
    reset = 1'b0;
    t_last = 0;
    for (int i = 0; i < 4; i++) begin
      wait_valid($sformatf("rr_wait%0d", i), ok);
      if (!ok) break;
      chk($sformatf("rr_gnt%0d", i), gnt, rr_gnt[i]);
      chk($sformatf("rr_dat%0d", i), rnd_data, rr_dat[i]);
      if (i > 0) chk($sformatf("rr_gap%0d", i), cyc - t_last, 2);
      t_last = cyc;
    end
    req = 2'b00;
    repeat (3) @(negedge clk_50);

    // Priority: seed_load, req and a fresh pending tick at once.
    run = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_50);
      if (tick && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("pri_tick_found", ok, 1'b1);
    seed_load = 1'b1; seed_in = 5'b10110; req = 2'b01;
    @(negedge clk_50);
    seed_load = 1'b0; run = 1'b0;
    chk("pri_load_busy", busy, 1'b1);
    chk("pri_load_lfsr", lfsr, 5'b10110);
    chk("pri_load_gnt", gnt, 2'b00);
    @(negedge clk_50);
    chk("pri_idle1", busy, 1'b0);
    @(negedge clk_50);
    chk("pri_grant_gnt", gnt, 2'b01);
    chk("pri_grant_dat", rnd_data, 5'b10110);
    chk("pri_grant_lfsr", lfsr, 5'b11011);
    req = 2'b00;
    @(negedge clk_50);
    chk("pri_idle2", busy, 1'b0);
    @(negedge clk_50);
    chk("pri_step_busy", busy, 1'b1);
    chk("pri_step_gnt", gnt, 2'b00);
    chk("pri_step_lfsr", lfsr, 5'b11101);
    repeat (3) @(negedge clk_50);

    // Asynchronous reset in the middle of a grant.
    req = 2'b10;
    wait_valid("ar_wait", ok);
    if (ok) begin
      #2 reset = 1'b1;
      #1;
      chk("ar_gnt", gnt, 2'b00);
      chk("ar_valid", rnd_valid, 1'b0);
      chk("ar_lfsr", lfsr, 5'b00001);
      chk("ar_busy", busy, 1'b0);
    end
    req = 2'b00;
    @(negedge clk_50);
    #2 reset = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_50);
      #2;
      reset     = ($urandom_range(0, 399) == 0);
      seed_load = ($urandom_range(0, 15) == 0);
      seed_in   = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 31) == 0) run = ~run;
      if ($urandom_range(0, 2) == 0) req = 2'($urandom_range(0, 3));
    end
    reset = 1'b0; seed_load = 1'b0; req = 2'b00; run = 1'b0;
    repeat (4) @(negedge clk_50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
